phys_reg_free_list: RTL and testbench

- Circular free list of physical register indices that shares the physical register file between rename (allocator) and commit (up to two releasers per cycle).
- Supplies the new pd that rename writes into the RAT.
- Reclaims old mappings at commit.
- On branch mispredict, restores itself to exactly the registers not held by the RRF.

---
 rtl/rv32i_types.sv | 8 +
 rtl/phys_reg_free_list.sv | 89 ++++++++
 tb/tb_phys_reg_free_list.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rename/commit types: physical and architectural register index widths.
// 64 physical registers back 32 architectural registers.
package rv32i_types;
    localparam int PHYS_REG_IDX = 5;
    localparam int ARCH_REG_IDX = 4;

    typedef logic [PHYS_REG_IDX:0] phys_reg_t;
endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register indices; rename pops pd, commit pushes up to two old pds.
// Latency: alloc_pd is combinational from head; releases become allocatable the cycle after the write.
// Backpressure: alloc_ready low when empty or flushing; releases that would overfill are dropped and flagged.
module phys_reg_free_list
    import rv32i_types::*;
#(
    parameter int FL_PHYS_REG_IDX = PHYS_REG_IDX,
    parameter int FL_ARCH_REG_IDX = ARCH_REG_IDX,
    parameter int FL_DEPTH        = (1 << (FL_PHYS_REG_IDX + 1)) - (1 << (FL_ARCH_REG_IDX + 1))
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alloc_req,
    output logic                          alloc_ready,
    output logic [FL_PHYS_REG_IDX:0]      alloc_pd,
    input  logic                          free_valid_0,
    input  logic [FL_PHYS_REG_IDX:0]      free_pd_0,
    input  logic                          free_valid_1,
    input  logic [FL_PHYS_REG_IDX:0]      free_pd_1,
    input  logic                          branch_mispredict,
    output logic [$clog2(FL_DEPTH):0]     free_count,
    output logic                          overflow_err
);
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int PD_W     = FL_PHYS_REG_IDX + 1;
    localparam int FIRST_PD = 1 << (FL_ARCH_REG_IDX + 1);

    logic [PD_W-1:0]  entries [FL_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] count_post;
    logic [PTR_W-1:0] count_mid;
    logic [PTR_W-1:0] tail_next;
    logic [IDX_W-1:0] wr_idx0;
    logic [IDX_W-1:0] wr_idx1;
    logic             grant;
    logic             want0;
    logic             want1;
    logic             accept0;
    logic             accept1;

    assign count       = tail - head;
    assign free_count  = count;
    assign alloc_ready = (count != '0) && !branch_mispredict;
    assign alloc_pd    = entries[head[IDX_W-1:0]];
    assign grant       = alloc_req && alloc_ready;

    // Room is judged on the post-grant count, so alloc plus release at full is legal.
    assign count_post = count - PTR_W'(grant);
    assign want0      = free_valid_0 && (free_pd_0 != '0);
    assign accept0    = want0 && (count_post < PTR_W'(FL_DEPTH));
    assign count_mid  = count_post + PTR_W'(accept0);
    assign want1      = free_valid_1 && (free_pd_1 != '0);
    assign accept1    = want1 && (count_mid < PTR_W'(FL_DEPTH));

    assign tail_next = tail + PTR_W'(accept0) + PTR_W'(accept1);
    assign wr_idx0   = tail[IDX_W-1:0];
    assign wr_idx1   = tail[IDX_W-1:0] + IDX_W'(accept0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entries[i] <= PD_W'(FIRST_PD + i);
            end
            head         <= '0;
            tail         <= {1'b1, {IDX_W{1'b0}}};
            overflow_err <= 1'b0;
        end else begin
            if (accept0) begin
                entries[wr_idx0] <= free_pd_0;
            end
            if (accept1) begin
                entries[wr_idx1] <= free_pd_1;
            end
            tail <= tail_next;
            // On flush the newest FL_DEPTH writes are exactly the pds the RRF does not hold.
            if (branch_mispredict) begin
                head <= {~tail_next[PTR_W-1], tail_next[IDX_W-1:0]};
            end else if (grant) begin
                head <= head + PTR_W'(1);
            end
            if ((want0 && !accept0) || (want1 && !accept1)) begin
                overflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized and directed bench for phys_reg_free_list against a queue-based free-list model.
module tb_phys_reg_free_list;
    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_ready;
    logic [5:0] alloc_pd;
    logic       free_valid_0;
    logic [5:0] free_pd_0;
    logic       free_valid_1;
    logic [5:0] free_pd_1;
    logic       branch_mispredict;
    logic [5:0] free_count;
    logic       overflow_err;

    int checks = 0;
    int errors = 0;

    // Model: q is the free list in allocation order, hist the last 32 pds written to the array.
    int q[$];
    int hist[$];
    bit ovf_m;

    always #5 clk = ~clk;

    phys_reg_free_list dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_pd(alloc_pd),
        .free_valid_0(free_valid_0), .free_pd_0(free_pd_0),
        .free_valid_1(free_valid_1), .free_pd_1(free_pd_1),
        .branch_mispredict(branch_mispredict),
        .free_count(free_count), .overflow_err(overflow_err)
    );

    function automatic void model_reset();
        q.delete();
        hist.delete();
        for (int i = 0; i < 32; i++) begin
            q.push_back(32 + i);
            hist.push_back(32 + i);
        end
        ovf_m = 1'b0;
    endfunction

    function automatic void model_release(bit v, int pd);
        if (v && pd != 0) begin
            if (q.size() < 32) begin
                q.push_back(pd);
                hist.push_back(pd);
                if (hist.size() > 32) void'(hist.pop_front());
            end else begin
                ovf_m = 1'b1;
            end
        end
    endfunction

    function automatic void model_step();
        bit rdy;
        if (rst) begin
            model_reset();
        end else begin
            rdy = (q.size() != 0) && !branch_mispredict;
            if (alloc_req && rdy) void'(q.pop_front());
            model_release(free_valid_0, int'(free_pd_0));
            model_release(free_valid_1, int'(free_pd_1));
            if (branch_mispredict) q = hist;
        end
    endfunction

    task automatic drive(input bit rs, input bit req, input bit v0, input int p0,
                         input bit v1, input int p1, input bit mp);
        @(negedge clk);
        rst = rs; alloc_req = req; branch_mispredict = mp;
        free_valid_0 = v0; free_pd_0 = 6'(p0);
        free_valid_1 = v1; free_pd_1 = 6'(p1);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (alloc_ready !== 1'b1 || alloc_pd !== 6'd32 || free_count !== 6'd32 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%0b pd=%0d count=%0d ovf=%0b, want 1 32 32 0",
                     alloc_ready, alloc_pd, free_count, overflow_err);
        end
    endtask

    task automatic test_drain_and_bypass();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            checks++;
            if (alloc_ready !== 1'b1 || alloc_pd !== 6'(32 + i)) begin
                errors++;
                $display("FAIL drain[%0d]: ready=%0b pd=%0d, want 1 %0d", i, alloc_ready, alloc_pd, 32 + i);
            end
            tick();
        end
        drive(0, 1, 1, 40, 0, 0, 0);
        checks++;
        if (alloc_ready !== 1'b0 || free_count !== 6'd0) begin
            errors++;
            $display("FAIL empty: ready=%0b count=%0d, want 0 0", alloc_ready, free_count);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (alloc_ready !== 1'b1 || alloc_pd !== 6'd40 || free_count !== 6'd1) begin
            errors++;
            $display("FAIL no_bypass: ready=%0b pd=%0d count=%0d, want 1 40 1", alloc_ready, alloc_pd, free_count);
        end
    endtask

    task automatic test_wrap();
        int exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 1, 7, 1, 9, 0);
        checks++;
        if (free_count !== 6'd28) begin
            errors++;
            $display("FAIL wrap_pre: count=%0d, want 28", free_count);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 6'd30) begin
            errors++;
            $display("FAIL wrap_post: count=%0d, want 30", free_count);
        end
        for (int k = 0; k < 30; k++) begin
            exp = (k < 28) ? 36 + k : ((k == 28) ? 7 : 9);
            drive(0, 1, 0, 0, 0, 0, 0);
            checks++;
            if (alloc_ready !== 1'b1 || alloc_pd !== 6'(exp)) begin
                errors++;
                $display("FAIL wrap_alloc[%0d]: ready=%0b pd=%0d, want 1 %0d", k, alloc_ready, alloc_pd, exp);
            end
            tick();
        end
    endtask

    task automatic test_mispredict();
        int exp;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 1, 1, 5, 0, 0, 1);
        checks++;
        if (alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: ready=%0b, want 0", alloc_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 6'd32 || alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_count: count=%0d ready=%0b, want 32 1", free_count, alloc_ready);
        end
        // Last 32 writes were 33..63 then 5 (pd 32 was overwritten by 5).
        for (int k = 0; k < 32; k++) begin
            exp = (k < 31) ? 33 + k : 5;
            drive(0, 1, 0, 0, 0, 0, 0);
            checks++;
            if (alloc_pd !== 6'(exp)) begin
                errors++;
                $display("FAIL flush_alloc[%0d]: pd=%0d, want %0d", k, alloc_pd, exp);
            end
            tick();
        end
    endtask

    task automatic test_overflow_and_zero();
        do_reset();
        drive(0, 0, 1, 12, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (overflow_err !== 1'b1 || free_count !== 6'd32) begin
            errors++;
            $display("FAIL overflow: ovf=%0b count=%0d, want 1 32", overflow_err, free_count);
        end
        do_reset();
        drive(0, 1, 1, 12, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (overflow_err !== 1'b0 || free_count !== 6'd32) begin
            errors++;
            $display("FAIL alloc_free_full: ovf=%0b count=%0d, want 0 32", overflow_err, free_count);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 6'd31 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL zero_pd: count=%0d ovf=%0b, want 31 0", free_count, overflow_err);
        end
        // One slot of room: slot 0 fits, slot 1 is dropped.
        drive(0, 0, 1, 20, 1, 21, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (free_count !== 6'd32 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL dual_partial: count=%0d ovf=%0b, want 32 1", free_count, overflow_err);
        end
    endtask

    task automatic test_random();
        bit rs, req, v0, v1, mp;
        int p0, p1;
        for (int c = 0; c < 3000; c++) begin
            rs  = ($urandom % 600) == 0;
            req = ($urandom % 4) != 0;
            v0  = ($urandom % 3) == 0;
            v1  = ($urandom % 4) == 0;
            p0  = (($urandom % 16) == 0) ? 0 : int'($urandom_range(1, 63));
            p1  = (($urandom % 16) == 0) ? 0 : int'($urandom_range(1, 63));
            mp  = ($urandom % 60) == 0;
            drive(rs, req, v0, p0, v1, p1, mp);
            checks++;
            if (alloc_ready !== ((q.size() != 0) && !mp)) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %0b want %0b", c, alloc_ready, (q.size() != 0) && !mp);
            end
            checks++;
            if (free_count !== 6'(q.size()) || overflow_err !== ovf_m) begin
                errors++;
                $display("FAIL rand_state[%0d]: count=%0d ovf=%0b, want %0d %0b",
                         c, free_count, overflow_err, q.size(), ovf_m);
            end
            if (q.size() != 0) begin
                checks++;
                if (alloc_pd !== 6'(q[0])) begin
                    errors++;
                    $display("FAIL rand_pd[%0d]: got %0d want %0d", c, alloc_pd, q[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 3 + i, 0, 0, 0);
            tick();
        end
        drive(0, 0, 1, 50, 0, 0, 0);
        tick();
        do_reset();
        checks++;
        if (alloc_ready !== 1'b1 || alloc_pd !== 6'd32 || free_count !== 6'd32 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ready=%0b pd=%0d count=%0d ovf=%0b, want 1 32 32 0",
                     alloc_ready, alloc_pd, free_count, overflow_err);
        end
    endtask

    initial begin
        rst = 1'b1; alloc_req = 1'b0; branch_mispredict = 1'b0;
        free_valid_0 = 1'b0; free_pd_0 = '0; free_valid_1 = 1'b0; free_pd_1 = '0;
        model_reset();
        test_reset();
        test_drain_and_bypass();
        test_wrap();
        test_mispredict();
        test_overflow_and_zero();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
